spi_master: RTL and testbench

- 8-bit SPI master; the initiating end of the team's existing single-slave SPI link.
- Generates SCLK, drives CS and MOSI, and captures MISO.
- Bus timing: SCLK idles low; the slave drives MISO on SCLK rising and samples MOSI on SCLK falling; LSB first.
- Sits between a local controller (start/busy/done handshake) and the off-block SPI pins.

---
 rtl/spi_master.sv | 164 ++++++++++++++++
 tb/tb_spi_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// 8-bit single-slave SPI master. SCLK idles low; the slave drives MISO on SCLK rising
// and samples MOSI on SCLK falling. Bit order is LSB first unless SPI_MASTER_MSB_FIRST_EN
// is defined, which reverses the order on both MOSI and MISO.
// Every bus phase (CS setup, SCLK high, SCLK low, CS hold, CS-high gap) lasts CLK_DIV clocks.
module spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] masterDataToSend,
    output logic [7:0] masterDataReceived,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       CS,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

    state_e     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rx_out_q, rx_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       sclk_q, sclk_d;
    logic       cs_q, cs_d;
    logic       mosi_q, mosi_d;
    logic       phase_last;

    // Final clock of the current CLK_DIV-long phase.
    assign phase_last = (div_cnt_q == 8'(CLK_DIV - 1));

    // Next-state logic for the transfer sequencer and all registered bus outputs.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = phase_last ? 8'd0 : div_cnt_q + 8'd1;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_out_d  = rx_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;

        case (state_q)
            StIdle: begin
                div_cnt_d = 8'd0;
                if (start) begin
                    tx_d      = masterDataToSend;
                    rx_d      = 8'h00;
                    bit_cnt_d = 3'd0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef SPI_MASTER_MSB_FIRST_EN
                    mosi_d    = masterDataToSend[7];
`else
                    mosi_d    = masterDataToSend[0];
`endif
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (phase_last) begin
                    sclk_d  = 1'b1;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                // MISO was launched on the rising edge; capture it just before SCLK falls.
                if (phase_last) begin
`ifdef SPI_MASTER_MSB_FIRST_EN
                    rx_d = {rx_q[6:0], MISO};
`else
                    rx_d = {MISO, rx_q[7:1]};
`endif
                    sclk_d  = 1'b0;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_last) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StHold;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        sclk_d    = 1'b1;
                        // Next data bit changes together with the rising edge.
`ifdef SPI_MASTER_MSB_FIRST_EN
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
`else
                        tx_d   = {1'b0, tx_q[7:1]};
                        mosi_d = tx_q[1];
`endif
                        state_d = StHigh;
                    end
                end
            end
            StHold: begin
                if (phase_last) begin
                    cs_d     = 1'b1;
                    rx_out_d = rx_q;
                    done_d   = 1'b1;
                    state_d  = StGap;
                end
            end
            StGap: begin
                // Minimum CS-high time so the slave always sees a fresh CS fall.
                if (phase_last) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rx_out_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_out_q  <= rx_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
        end
    end

    assign masterDataReceived = rx_out_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign SCLK               = sclk_q;
    assign CS                 = cs_q;
    assign MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: DUT a (CLK_DIV=2) paired with an LSB-first slave model,
// DUT b (CLK_DIV=1) with MISO tied high. Expected wire-order values follow the
// SPI_MASTER_MSB_FIRST_EN build setting.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_start, a_busy, a_done, a_sclk, a_cs, a_mosi;
    logic       a_miso = 1'b0;
    logic [7:0] a_tx, a_rx;
    logic       b_start, b_busy, b_done, b_sclk, b_cs, b_mosi, b_miso;
    logic [7:0] b_tx, b_rx;

    int n_cmp  = 0;
    int n_fail = 0;

    spi_master #(.CLK_DIV(2)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .masterDataToSend(a_tx),
        .masterDataReceived(a_rx), .busy(a_busy), .done(a_done), .SCLK(a_sclk),
        .CS(a_cs), .MOSI(a_mosi), .MISO(a_miso)
    );

    spi_master #(.CLK_DIV(1)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .masterDataToSend(b_tx),
        .masterDataReceived(b_rx), .busy(b_busy), .done(b_done), .SCLK(b_sclk),
        .CS(b_cs), .MOSI(b_mosi), .MISO(b_miso)
    );

    // LSB-first slave model: drives MISO on SCLK rise, samples MOSI on SCLK fall.
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_idx = 0;

    always @(negedge a_cs or posedge a_sclk) begin
        if (a_sclk) begin
            if (!a_cs && s_idx < 8) begin
                a_miso = s_tx[s_idx];
                s_idx  = s_idx + 1;
            end
        end else begin
            s_idx = 0;
        end
    end

    always @(negedge a_sclk) begin
        if (!a_cs) s_rx = {a_mosi, s_rx[7:1]};
    end

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // How an LSB-first byte appears after crossing the wire in this build.
    function automatic logic [7:0] order(input logic [7:0] v);
`ifdef SPI_MASTER_MSB_FIRST_EN
        return bitrev(v);
`else
        return v;
`endif
    endfunction

    // Start one transfer on DUT a and watch it until busy drops (j = negedges after accept).
    task automatic run_a(input logic [7:0] data, input int poke_a, input int poke_b,
                         output int done_j, output int n_done, output int n_pulse,
                         output logic [7:0] mosi_seen, output logic wide, output int end_j);
        int   j;
        logic prev_s, prev_d;
        @(negedge clk);
        a_start = 1'b1;
        a_tx    = data;
        @(negedge clk);
        a_start = 1'b0;
        a_tx    = ~data;
        j = 0; done_j = -1; n_done = 0; n_pulse = 0; mosi_seen = 8'h00; wide = 1'b0;
        prev_s = a_sclk; prev_d = a_done;
        while (a_busy && j < 200) begin
            a_start = (j == poke_a || j == poke_b) ? 1'b1 : 1'b0;
            @(negedge clk);
            j++;
            if (a_sclk && !prev_s) begin
                if (n_pulse < 8) mosi_seen[n_pulse] = a_mosi;
                n_pulse++;
            end
            if (a_done) begin
                n_done++;
                if (done_j < 0) done_j = j;
                if (prev_d) wide = 1'b1;
            end
            prev_s = a_sclk;
            prev_d = a_done;
        end
        a_start = 1'b0;
        end_j = j;
        n_cmp++;
        if (a_busy) begin
            n_fail++;
            $display("FAIL run_a_timeout: busy still %b after %0d cycles, want 0", a_busy, j);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_start = 1'b0; a_tx = 8'h00; b_start = 1'b0; b_tx = 8'h00; b_miso = 1'b1;
        #12;
        n_cmp++; if (a_cs !== 1'b1) begin n_fail++; $display("FAIL rst_cs: got %b want 1", a_cs); end
        n_cmp++; if (a_sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", a_sclk); end
        n_cmp++; if (a_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", a_mosi); end
        n_cmp++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy_done: got %b%b want 00", a_busy, a_done); end
        n_cmp++; if (a_rx !== 8'h00 || b_rx !== 8'h00) begin
            n_fail++; $display("FAIL rst_rx: got %h/%h want 00/00", a_rx, b_rx); end
        n_cmp++; if (b_cs !== 1'b1 || b_sclk !== 1'b0) begin
            n_fail++; $display("FAIL rst_b_pins: got cs=%b sclk=%b want 1/0", b_cs, b_sclk); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_busy !== 1'b0 || a_cs !== 1'b1) begin
            n_fail++; $display("FAIL idle_after_rst: got busy=%b cs=%b want 0/1", a_busy, a_cs); end
    endtask

    task automatic test_basic();
        int dj, nd, np, ej; logic [7:0] ms; logic w;
        s_tx = 8'h3C;
        run_a(8'hA5, -1, -1, dj, nd, np, ms, w, ej);
        n_cmp++; if (a_rx !== order(8'h3C)) begin n_fail++; $display("FAIL basic_rx: got %h want %h", a_rx, order(8'h3C)); end
        n_cmp++; if (s_rx !== order(8'hA5)) begin n_fail++; $display("FAIL basic_slave_rx: got %h want %h", s_rx, order(8'hA5)); end
        n_cmp++; if (dj !== 36) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 36", dj); end
        n_cmp++; if (nd !== 1 || w !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got n=%0d wide=%b want 1/0", nd, w); end
        n_cmp++; if (np !== 8) begin n_fail++; $display("FAIL basic_pulses: got %0d want 8", np); end
        n_cmp++; if (ms !== order(8'hA5)) begin n_fail++; $display("FAIL basic_mosi: got %h want %h", ms, order(8'hA5)); end
        n_cmp++; if (ej !== 38) begin n_fail++; $display("FAIL basic_busy_end: got %0d want 38", ej); end
    endtask

    task automatic test_div1();
        int j, np, cs_low, dj; logic prev_s; logic [7:0] ms;
        @(negedge clk);
        b_start = 1'b1; b_tx = 8'h01;
        @(negedge clk);
        b_start = 1'b0; b_tx = 8'hFE;
        j = 0; np = 0; dj = -1; ms = 8'h00; prev_s = b_sclk;
        cs_low = (b_cs == 1'b0) ? 1 : 0;
        while (b_busy && j < 100) begin
            @(negedge clk);
            j++;
            if (!b_cs) cs_low++;
            if (b_sclk && !prev_s) begin
                if (np < 8) ms[np] = b_mosi;
                np++;
            end
            if (b_done && dj < 0) dj = j;
            prev_s = b_sclk;
        end
        n_cmp++; if (np !== 8) begin n_fail++; $display("FAIL div1_pulses: got %0d want 8", np); end
        n_cmp++; if (ms !== order(8'h01)) begin n_fail++; $display("FAIL div1_mosi: got %h want %h", ms, order(8'h01)); end
        n_cmp++; if (b_rx !== 8'hFF) begin n_fail++; $display("FAIL div1_rx: got %h want ff", b_rx); end
        n_cmp++; if (cs_low !== 18) begin n_fail++; $display("FAIL div1_cs_low: got %0d want 18", cs_low); end
        n_cmp++; if (dj !== 18) begin n_fail++; $display("FAIL div1_done_cycle: got %0d want 18", dj); end
        n_cmp++; if (j !== 19) begin n_fail++; $display("FAIL div1_busy_end: got %0d want 19", j); end
    endtask

    task automatic test_back_to_back();
        int j, nd, np, cs_high, acc2, dj1, dj2; logic prev_s, prev_d, prev_cs, w;
        logic [7:0] rx1, rx2, sr1, sr2;
        s_tx = 8'h96;
        @(negedge clk);
        a_start = 1'b1; a_tx = 8'h55;
        @(negedge clk);
        a_tx = 8'hAA;
        j = 0; nd = 0; np = 0; cs_high = 0; acc2 = -1; dj1 = -1; dj2 = -1; w = 1'b0;
        rx1 = 8'h00; rx2 = 8'h00; sr1 = 8'h00; sr2 = 8'h00;
        prev_s = a_sclk; prev_d = a_done; prev_cs = a_cs;
        while (j < 85) begin
            if (j == 40) a_start = 1'b0;
            @(negedge clk);
            j++;
            if (a_sclk && !prev_s) np++;
            if (a_cs && j < 60) cs_high++;
            if (!a_cs && prev_cs && acc2 < 0) acc2 = j;
            if (a_done) begin
                if (prev_d) w = 1'b1;
                if (nd == 0) begin dj1 = j; rx1 = a_rx; sr1 = s_rx; end
                else begin dj2 = j; rx2 = a_rx; sr2 = s_rx; end
                nd++;
            end
            prev_s = a_sclk; prev_d = a_done; prev_cs = a_cs;
        end
        n_cmp++; if (nd !== 2 || w !== 1'b0) begin n_fail++; $display("FAIL b2b_done_count: got n=%0d wide=%b want 2/0", nd, w); end
        n_cmp++; if (dj1 !== 36 || dj2 !== 75) begin n_fail++; $display("FAIL b2b_done_cycles: got %0d/%0d want 36/75", dj1, dj2); end
        n_cmp++; if (acc2 !== 39) begin n_fail++; $display("FAIL b2b_second_accept: got %0d want 39", acc2); end
        n_cmp++; if (cs_high !== 3) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want 3", cs_high); end
        n_cmp++; if (np !== 16) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 16", np); end
        n_cmp++; if (sr1 !== order(8'h55) || sr2 !== order(8'hAA)) begin
            n_fail++; $display("FAIL b2b_slave_rx: got %h/%h want %h/%h", sr1, sr2, order(8'h55), order(8'hAA)); end
        n_cmp++; if (rx1 !== order(8'h96) || rx2 !== order(8'h96)) begin
            n_fail++; $display("FAIL b2b_rx: got %h/%h want %h", rx1, rx2, order(8'h96)); end
        n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", a_busy); end
    endtask

    task automatic test_busy_ignore();
        int dj, nd, np, ej; logic [7:0] ms; logic w;
        s_tx = 8'h5A;
        run_a(8'h3B, 5, 37, dj, nd, np, ms, w, ej);
        n_cmp++; if (np !== 8) begin n_fail++; $display("FAIL ign_pulses: got %0d want 8", np); end
        n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", nd); end
        n_cmp++; if (s_rx !== order(8'h3B)) begin n_fail++; $display("FAIL ign_slave_rx: got %h want %h", s_rx, order(8'h3B)); end
        n_cmp++; if (a_rx !== order(8'h5A)) begin n_fail++; $display("FAIL ign_rx: got %h want %h", a_rx, order(8'h5A)); end
        repeat (4) @(negedge clk);
        n_cmp++; if (a_busy !== 1'b0 || a_cs !== 1'b1) begin
            n_fail++; $display("FAIL ign_no_queue: got busy=%b cs=%b want 0/1", a_busy, a_cs); end
    endtask

    task automatic test_reset_abort();
        int j, np, dj, nd, ej; logic prev_s, w; logic [7:0] ms;
        s_tx = 8'hE7;
        @(negedge clk);
        a_start = 1'b1; a_tx = 8'h12;
        @(negedge clk);
        a_start = 1'b0;
        j = 0; np = 0; prev_s = a_sclk;
        while (!(np == 4 && !a_sclk) && j < 100) begin
            @(negedge clk);
            j++;
            if (a_sclk && !prev_s) np++;
            prev_s = a_sclk;
        end
        n_cmp++; if (j !== 16) begin n_fail++; $display("FAIL abort_fourth_fall: got %0d want 16", j); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (a_cs !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_immediate: got cs=%b sclk=%b busy=%b want 1/0/0", a_cs, a_sclk, a_busy); end
        n_cmp++; if (a_rx !== 8'h00) begin n_fail++; $display("FAIL abort_rx: got %h want 00", a_rx); end
        @(negedge clk);
        reset = 1'b1;
        s_tx = 8'h81;
        run_a(8'hC3, -1, -1, dj, nd, np, ms, w, ej);
        n_cmp++; if (s_rx !== order(8'hC3)) begin n_fail++; $display("FAIL after_abort_slave_rx: got %h want %h", s_rx, order(8'hC3)); end
        n_cmp++; if (a_rx !== order(8'h81)) begin n_fail++; $display("FAIL after_abort_rx: got %h want %h", a_rx, order(8'h81)); end
        n_cmp++; if (dj !== 36 || np !== 8) begin n_fail++; $display("FAIL after_abort_timing: got done=%0d pulses=%0d want 36/8", dj, np); end
    endtask

    task automatic test_bit_order();
        int dj, nd, np, ej; logic [7:0] ms; logic w;
        s_tx = 8'h0F;
        run_a(8'h80, -1, -1, dj, nd, np, ms, w, ej);
        n_cmp++; if (ms !== order(8'h80)) begin n_fail++; $display("FAIL order_mosi: got %h want %h", ms, order(8'h80)); end
        n_cmp++; if (a_rx !== order(8'h0F)) begin n_fail++; $display("FAIL order_rx: got %h want %h", a_rx, order(8'h0F)); end
        n_cmp++; if (s_rx !== order(8'h80)) begin n_fail++; $display("FAIL order_slave_rx: got %h want %h", s_rx, order(8'h80)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div1();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_bit_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
